// File: rtl/ual_seq_pkg.sv
// Shared definitions for the UAL sequencer: FSM states, opcodes, instruction
// field positions and strobe bit ordering.
package ual_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECODE = 2'd1,
    ST_EXEC   = 2'd2
  } state_t;

  localparam int OP_MSB  = 7;
  localparam int OP_LSB  = 5;
  localparam int SEL_MSB = 2;
  localparam int SEL_LSB = 0;

  localparam logic [2:0] OP_NOP   = 3'b000;
  localparam logic [2:0] OP_LDR1  = 3'b001;
  localparam logic [2:0] OP_ALU   = 3'b010;
  localparam logic [2:0] OP_ALUNC = 3'b011;
  localparam logic [2:0] OP_CLRC  = 3'b100;
  localparam logic [2:0] OP_SKIPC = 3'b101;

  // Bit positions inside the 4-bit strobe vector {load_r1, load_accu, load_carry, init_carry}.
  localparam int STB_R1    = 3;
  localparam int STB_ACCU  = 2;
  localparam int STB_CARRY = 1;
  localparam int STB_INIT  = 0;

  // Only ALU-class instructions are allowed to change the datapath select.
  function automatic logic is_alu_class(input logic [2:0] op);
    return (op == OP_ALU) || (op == OP_ALUNC);
  endfunction

endpackage

// File: rtl/ual_seq_decode.sv
// Combinational opcode-to-strobe mapping for the UAL sequencer.
// Opcode 101 (SKIPC) is only legal when UAL_SEQ_SKIPC_EN is defined.
module ual_seq_decode
  import ual_seq_pkg::*;
(
  input  logic [2:0] opcode,
  output logic [3:0] strobes,
  output logic       legal
`ifdef UAL_SEQ_SKIPC_EN
  , output logic     is_skipc
`endif
);

  always_comb begin
    strobes = '0;
    legal   = 1'b1;
`ifdef UAL_SEQ_SKIPC_EN
    is_skipc = 1'b0;
`endif
    case (opcode)
      OP_NOP:   ;
      OP_LDR1:  strobes[STB_R1] = 1'b1;
      OP_ALU: begin
        strobes[STB_ACCU]  = 1'b1;
        strobes[STB_CARRY] = 1'b1;
      end
      OP_ALUNC: strobes[STB_ACCU] = 1'b1;
      // init_carry and load_carry never share an opcode, so never fire together.
      OP_CLRC:  strobes[STB_INIT] = 1'b1;
`ifdef UAL_SEQ_SKIPC_EN
      OP_SKIPC: is_skipc = 1'b1;
`endif
      default:  legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/ual_sequencer.sv
// UAL instruction sequencer: IDLE -> DECODE -> EXEC, one strobe cycle per instruction.
// Optional conditional-skip instruction (SKIPC) enabled by UAL_SEQ_SKIPC_EN.
module ual_sequencer
  import ual_seq_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] instr,
  input  logic       instr_valid,
  output logic       instr_ready,
  input  logic       carry,
  output logic [2:0] sel_ual,
  output logic       load_r1,
  output logic       load_accu,
  output logic       load_carry,
  output logic       init_carry,
  output logic       busy,
  output logic       illegal,
  output logic [7:0] exec_count,
  output logic [1:0] dbg_state
);

  // Handshake: an instruction is taken when instr_valid && instr_ready on a
  // rising edge; instr_ready is high only in IDLE, and while busy the inputs
  // are ignored entirely (the source keeps instr_valid asserted until taken).

  state_t     state_q, state_d;
  logic [2:0] op_q;
  logic [2:0] sel_q;
  logic       illegal_q;
  logic [7:0] count_q;
  logic [3:0] dec_strobes;
  logic       dec_legal;
  logic       accept;
  logic       skip_now;
  logic       exec_en;
  logic       unused_bits;

  assign accept      = instr_valid && (state_q == ST_IDLE);
  assign unused_bits = ^{instr[4:3], carry};

`ifdef UAL_SEQ_SKIPC_EN
  logic dec_skipc;
  logic skip_flag_q;
  logic skip_cur_q;

  ual_seq_decode u_decode (
    .opcode   (op_q),
    .strobes  (dec_strobes),
    .legal    (dec_legal),
    .is_skipc (dec_skipc)
  );

  assign skip_now = skip_cur_q;

  // skip_cur_q marks the instruction in flight as skipped; the pending flag
  // is consumed by whichever instruction is accepted next.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skip_flag_q <= 1'b0;
      skip_cur_q  <= 1'b0;
    end else if (accept) begin
      skip_cur_q  <= skip_flag_q;
      skip_flag_q <= 1'b0;
    end else if ((state_q == ST_EXEC) && dec_skipc && !skip_cur_q && carry) begin
      skip_flag_q <= 1'b1;
    end
  end
`else
  ual_seq_decode u_decode (
    .opcode  (op_q),
    .strobes (dec_strobes),
    .legal   (dec_legal)
  );

  assign skip_now = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (accept) state_d = ST_DECODE;
      ST_DECODE: state_d = dec_legal ? ST_EXEC : ST_IDLE;
      ST_EXEC:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q      <= OP_NOP;
      sel_q     <= '0;
      illegal_q <= 1'b0;
      count_q   <= '0;
    end else begin
      if (accept) begin
        op_q <= instr[OP_MSB:OP_LSB];
      end
`ifdef UAL_SEQ_SKIPC_EN
      if (accept && is_alu_class(instr[OP_MSB:OP_LSB]) && !skip_flag_q) begin
`else
      if (accept && is_alu_class(instr[OP_MSB:OP_LSB])) begin
`endif
        sel_q <= instr[SEL_MSB:SEL_LSB];
      end
      if ((state_q == ST_DECODE) && !dec_legal) begin
        illegal_q <= 1'b1;
      end
      if (exec_en) begin
        count_q <= count_q + 8'd1;
      end
    end
  end

  // Strobes decode straight from the state register so an asynchronous reset
  // removes them in the same cycle.
  assign exec_en     = (state_q == ST_EXEC) && !skip_now;
  assign load_r1     = exec_en && dec_strobes[STB_R1];
  assign load_accu   = exec_en && dec_strobes[STB_ACCU];
  assign load_carry  = exec_en && dec_strobes[STB_CARRY];
  assign init_carry  = exec_en && dec_strobes[STB_INIT];

  assign instr_ready = (state_q == ST_IDLE);
  assign busy        = (state_q != ST_IDLE);
  assign sel_ual     = sel_q;
  assign illegal     = illegal_q;
  assign exec_count  = count_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_ual_sequencer.sv
// Directed, table-driven bench for ual_sequencer; SKIPC cases compile in when
// UAL_SEQ_SKIPC_EN is defined, otherwise opcode 101 is checked as illegal.
module tb_ual_sequencer;
  import ual_seq_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] instr;
  logic       instr_valid;
  logic       instr_ready;
  logic       carry;
  logic [2:0] sel_ual;
  logic       load_r1, load_accu, load_carry, init_carry;
  logic       busy, illegal;
  logic [7:0] exec_count;
  logic [1:0] dbg_state;

  int checks   = 0;
  int failures = 0;
  logic [3:0] exp_q[$];

  typedef struct {
    logic [7:0] instr;
    logic       carry;
    logic       exp_legal;
    logic [2:0] exp_sel;
    logic [3:0] exp_strb;   // {load_r1, load_accu, load_carry, init_carry}
    logic [7:0] exp_count;
    logic       exp_illegal;
  } vec_t;

  ual_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .carry       (carry),
    .sel_ual     (sel_ual),
    .load_r1     (load_r1),
    .load_accu   (load_accu),
    .load_carry  (load_carry),
    .init_carry  (init_carry),
    .busy        (busy),
    .illegal     (illegal),
    .exec_count  (exec_count),
    .dbg_state   (dbg_state)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] strb();
    return {load_r1, load_accu, load_carry, init_carry};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    instr_valid = 1'b0;
    instr       = 8'h00;
    carry       = 1'b0;
    rst_n       = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", instr_ready, 1);
  endtask

  // Issues one instruction from IDLE and checks every cycle through N+3.
  task automatic do_vec(input vec_t v);
    @(posedge clk);
    #1;
    instr       = v.instr;
    carry       = v.carry;
    instr_valid = 1'b1;
    @(negedge clk);
    check("ready_n", instr_ready, 1);
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    instr       = ~v.instr;
    @(negedge clk);
    check("sel_n1", sel_ual, v.exp_sel);
    check("strb_n1", strb(), 4'b0000);
    check("state_n1", dbg_state, ST_DECODE);
    if (v.exp_legal) begin
      @(negedge clk);
      exp_q.push_back(v.exp_strb);
      check("strb_n2", strb(), exp_q.pop_front());
      check("busy_n2", busy, 1);
      @(negedge clk);
      check("ready_n3", instr_ready, 1);
      check("strb_n3", strb(), 4'b0000);
    end else begin
      @(negedge clk);
      check("ready_n2_illegal", instr_ready, 1);
      check("strb_n2_illegal", strb(), 4'b0000);
    end
    check("count", exec_count, v.exp_count);
    check("illegal", illegal, v.exp_illegal);
    check("sel_hold", sel_ual, v.exp_sel);
  endtask

  // Fast NOP issue for the wrap test: valid in N, back in IDLE at N+3.
  task automatic run_nop();
    @(posedge clk);
    #1;
    instr       = 8'h00;
    instr_valid = 1'b1;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  vec_t       vecs[10];
  vec_t       skipv[7];
  logic [3:0] b2b_exp[6];

  initial begin
    // instr, carry, legal, sel, strobes, count, illegal
    vecs[0] = '{8'h45, 1'b0, 1'b1, 3'd5, 4'b0110, 8'd1, 1'b0};
    vecs[1] = '{8'h20, 1'b0, 1'b1, 3'd5, 4'b1000, 8'd2, 1'b0};
    vecs[2] = '{8'h80, 1'b0, 1'b1, 3'd5, 4'b0001, 8'd3, 1'b0};
    vecs[3] = '{8'h63, 1'b0, 1'b1, 3'd3, 4'b0100, 8'd4, 1'b0};
    vecs[4] = '{8'h00, 1'b0, 1'b1, 3'd3, 4'b0000, 8'd5, 1'b0};
    vecs[5] = '{8'h5A, 1'b0, 1'b1, 3'd2, 4'b0110, 8'd6, 1'b0};
    vecs[6] = '{8'hE0, 1'b0, 1'b0, 3'd2, 4'b0000, 8'd6, 1'b1};
    vecs[7] = '{8'h00, 1'b0, 1'b1, 3'd2, 4'b0000, 8'd7, 1'b1};
    vecs[8] = '{8'hC7, 1'b0, 1'b0, 3'd2, 4'b0000, 8'd7, 1'b1};
    vecs[9] = '{8'h41, 1'b0, 1'b1, 3'd1, 4'b0110, 8'd8, 1'b1};

    skipv[0] = '{8'hA0, 1'b1, 1'b1, 3'd0, 4'b0000, 8'd1, 1'b0};
    skipv[1] = '{8'h45, 1'b1, 1'b1, 3'd0, 4'b0000, 8'd1, 1'b0};
    skipv[2] = '{8'hA0, 1'b0, 1'b1, 3'd0, 4'b0000, 8'd2, 1'b0};
    skipv[3] = '{8'h45, 1'b0, 1'b1, 3'd5, 4'b0110, 8'd3, 1'b0};
    skipv[4] = '{8'hA0, 1'b1, 1'b1, 3'd5, 4'b0000, 8'd4, 1'b0};
    skipv[5] = '{8'hA0, 1'b1, 1'b1, 3'd5, 4'b0000, 8'd4, 1'b0};
    skipv[6] = '{8'h44, 1'b1, 1'b1, 3'd4, 4'b0110, 8'd5, 1'b0};

    b2b_exp = '{4'b0000, 4'b0000, 4'b1000, 4'b0000, 4'b0000, 4'b0001};

    // Reset state.
    do_reset();
    check("rst_sel", sel_ual, 0);
    check("rst_strb", strb(), 4'b0000);
    check("rst_busy", busy, 0);
    check("rst_illegal", illegal, 0);
    check("rst_count", exec_count, 0);
    check("rst_state", dbg_state, ST_IDLE);

    foreach (vecs[i]) do_vec(vecs[i]);

    // Back-to-back LDR1 then CLRC with instr_valid held; CLRC taken at N+3.
    do_reset();
    @(posedge clk);
    #1;
    instr       = 8'h20;
    instr_valid = 1'b1;
    @(negedge clk);
    check("b2b_ready_n", instr_ready, 1);
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk);
      #1;
      if (c == 1) instr = 8'h80;
      if (c == 4) instr_valid = 1'b0;
      @(negedge clk);
      check($sformatf("b2b_strb_n%0d", c), strb(), b2b_exp[c]);
      if (c == 3) check("b2b_ready_n3", instr_ready, 1);
    end
    @(negedge clk);
    check("b2b_ready_n6", instr_ready, 1);
    check("b2b_count", exec_count, 2);
    check("b2b_sel", sel_ual, 0);

`ifdef UAL_SEQ_SKIPC_EN
    do_reset();
    foreach (skipv[i]) do_vec(skipv[i]);
`else
    do_reset();
    do_vec('{8'hA0, 1'b1, 1'b0, 3'd0, 4'b0000, 8'd0, 1'b1});
`endif

    // exec_count wraps after 256 instructions.
    do_reset();
    repeat (255) run_nop();
    @(negedge clk);
    check("wrap_255", exec_count, 255);
    run_nop();
    @(negedge clk);
    check("wrap_0", exec_count, 0);

    // Reset in the middle of EXEC of 8'h45.
    do_reset();
    do_vec(vecs[0]);
    @(posedge clk);
    #1;
    instr       = 8'h45;
    instr_valid = 1'b1;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("mid_exec_strb", strb(), 4'b0110);
    #2 rst_n = 1'b0;
    #1;
    check("abort_strb", strb(), 4'b0000);
    check("abort_sel", sel_ual, 0);
    check("abort_count", exec_count, 0);
    check("abort_busy", busy, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("abort_ready", instr_ready, 1);
    check("abort_strb_after", strb(), 4'b0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog: the directed sequence is short, so a stall means a bench or DUT hang.
  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ual_sequencer.md
UAL_SEQUENCER -- requirements
Module: ual_sequencer

Interface
REQ-001 SHALL have ports: clk  input  1  rising-edge clock, sole clock domain.
REQ-002 SHALL have: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-003 SHALL have: instr  input  8  instruction word; opcode in [7:5], ALU select in [2:0].
REQ-004 SHALL have: instr_valid  input  1  instr present this cycle.
REQ-005 SHALL have: instr_ready  output  1  sequencer accepts instr this cycle.
REQ-006 SHALL have: carry  input  1  carry flag returned by the datapath.
REQ-007 SHALL have: sel_ual  output  3  ALU operation select to the datapath.
REQ-008 SHALL have: load_r1, load_accu, load_carry, init_carry  output  1 each  datapath strobes, one-cycle pulses.
REQ-009 SHALL have: busy  output  1 (high when not IDLE); illegal  output  1 (sticky error).
REQ-010 SHALL have: exec_count  output  8  count of executed instructions.

Function
REQ-011 SHALL implement the FSM IDLE -> DECODE -> EXEC -> IDLE; instr_ready = (state==IDLE).
REQ-012 SHALL capture instr when instr_valid && instr_ready in cycle N; DECODE in N+1; EXEC in N+2; IDLE again in N+3.
REQ-013 SHALL drive sel_ual from captured instr[2:0] from cycle N+1, holding it until the next ALU-class instruction reaches DECODE.
REQ-014 SHALL assert exactly one cycle of strobes, in EXEC only, per opcode: 000 NOP none; 001 LDR1 load_r1; 010 ALU load_accu+load_carry; 011 ALUNC load_accu; 100 CLRC init_carry.
REQ-015 SHALL never assert init_carry and load_carry in the same cycle.
REQ-016 SHALL treat opcodes 110, 111 (and 101 when REQ-024 is disabled) as illegal: set illegal, no strobes, DECODE returns to IDLE (ready again at N+2).
REQ-017 SHALL hold illegal high until reset; subsequent legal instructions execute normally.
REQ-018 SHALL increment exec_count in EXEC for every non-skipped legal instruction, including NOP; wrap 255 -> 0.
REQ-019 SHALL ignore instr and instr_valid while busy (no buffering; the source holds instr_valid).

Reset
REQ-020 SHALL, on rst_n low, immediately force state IDLE, sel_ual 0, all strobes 0, illegal 0, exec_count 0, skip flag 0.
REQ-021 SHALL abort any in-flight instruction on reset mid-DECODE/EXEC with no strobe emitted.
REQ-022 SHALL present instr_ready=1 in the first cycle after rst_n deasserts.

Configuration
REQ-023 SHALL use macro UAL_SEQ_SKIPC_EN.
REQ-024 SHALL, with the macro defined, decode opcode 101 SKIPC: sample carry in EXEC; if 1, set skip flag; the next accepted instruction runs DECODE/EXEC with no strobes, no sel_ual update, no count, then clears the flag.
REQ-025 SHALL, with the macro defined, let SKIPC itself count as executed; a skipped SKIPC does not re-arm the flag.
REQ-026 SHALL, without the macro, contain no skip flag logic; 101 is illegal per REQ-016.

Structure
REQ-027 SHALL place opcode constants, state enum, and field positions in package ual_seq_pkg.
REQ-028 SHALL implement the opcode-to-strobe mapping in a combinational sub-module ual_seq_decode.

Verification
REQ-029 Reset then instr=8'h45 (ALU, sel 5) valid at N -> sel_ual=5 from N+1; load_accu=load_carry=1 at N+2 only; exec_count=1; ready at N+3.
REQ-030 Back-to-back valid 8'h20 (LDR1), 8'h80 (CLRC) -> load_r1 at N+2, init_carry at N+5, no other strobes.
REQ-031 instr=8'hE0 -> illegal=1, no strobes, ready at N+2; then 8'h00 -> exec_count increments, illegal stays 1.
REQ-032 With UAL_SEQ_SKIPC_EN, carry=1, SKIPC then 8'h45 -> no strobes for 8'h45, sel_ual unchanged, exec_count +1 total; carry=0 -> 8'h45 executes.
REQ-033 256 NOPs from exec_count 0 -> exec_count returns to 0.
REQ-034 rst_n low during EXEC of 8'h45 -> strobes 0 in the same cycle, sel_ual 0, ready=1 after release.
